// File: rtl/rr_sel_sequencer_pkg.sv
// Shared constants, state encoding and index helper for the round-robin select sequencer.
package rr_sel_sequencer_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Channel index that follows 'cur' in circular order.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] cur);
        return cur + {{(SEL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_next_index.sv
// Combinational round-robin candidate search starting just after the last granted channel.
import rr_sel_sequencer_pkg::*;

module rr_next_index (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    input  logic             skip_idle,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand_s;

    // Walk from the farthest offset down so the nearest requester after 'last' wins.
    always_comb begin
        idx    = next_ch(last);
        found  = 1'b0;
        cand_s = last;
        if (skip_idle) begin
            for (int k = N_CH; k >= 1; k--) begin
                cand_s = SEL_W'(int'(last) + k);
                idx    = req[cand_s] ? cand_s : idx;
                found  = found | req[cand_s];
            end
        end else begin
            found = 1'b1;
        end
    end

endmodule

// File: rtl/rr_sel_sequencer.sv
// Round-robin select sequencer: grants channels for fixed-length slots and drives registered sel/strobes.
import rr_sel_sequencer_pkg::*;

module rr_sel_sequencer #(
    parameter int SLOT_CYCLES = 4,
    parameter bit SKIP_IDLE   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             slot_start,
    output logic             busy
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [SEL_W-1:0] last_r, last_s;
    logic [SEL_W-1:0] sel_r, sel_s;
    logic             sel_valid_r, sel_valid_s;
    logic             slot_start_r, slot_start_s;
    logic             busy_r, busy_s;

    logic [SEL_W-1:0] idx_s;
    logic             found_s;
    logic             grant_s;

    rr_next_index u_next (
        .req       (req),
        .last      (last_r),
        .skip_idle (SKIP_IDLE),
        .idx       (idx_s),
        .found     (found_s)
    );

    // A new slot may start from IDLE or back-to-back when the current slot is on its last cycle.
    always_comb begin
        grant_s = en && found_s && ((state_r == ST_IDLE) || (cnt_r == CNT_ZERO));
    end

    // Next-state and next-output logic; everything holds unless granting or counting down.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_s       = last_r;
        sel_s        = sel_r;
        sel_valid_s  = sel_valid_r;
        slot_start_s = slot_start_r;
        busy_s       = busy_r;
        if (grant_s) begin
            state_s      = ST_HOLD;
            cnt_s        = CNT_RELOAD;
            last_s       = idx_s;
            sel_s        = idx_s;
            sel_valid_s  = 1'b1;
            slot_start_s = 1'b1;
            busy_s       = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    slot_start_s = 1'b0;
                end
                ST_HOLD: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s        = cnt_r - CNT_ONE;
                        slot_start_s = 1'b0;
                    end else begin
                        state_s      = ST_IDLE;
                        sel_valid_s  = 1'b0;
                        slot_start_s = 1'b0;
                        busy_s       = 1'b0;
                    end
                end
                default: begin
                    state_s      = ST_IDLE;
                    cnt_s        = CNT_ZERO;
                    sel_valid_s  = 1'b0;
                    slot_start_s = 1'b0;
                    busy_s       = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers; reset parks the pointer on the last channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            last_r       <= SEL_W'(N_CH - 1);
            sel_r        <= {SEL_W{1'b0}};
            sel_valid_r  <= 1'b0;
            slot_start_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_r       <= last_s;
            sel_r        <= sel_s;
            sel_valid_r  <= sel_valid_s;
            slot_start_r <= slot_start_s;
            busy_r       <= busy_s;
        end
    end

    assign sel        = sel_r;
    assign sel_valid  = sel_valid_r;
    assign slot_start = slot_start_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_rr_sel_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [3:0] req_a, req_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b, start_a, start_b, busy_a, busy_b;

    typedef struct {
        bit         dut_b;
        logic [1:0] sel;
        logic       valid;
        logic       start;
        logic       busy;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;
    logic [4:0] act, want;

    rr_sel_sequencer #(.SLOT_CYCLES(4), .SKIP_IDLE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .req(req_a),
        .sel(sel_a), .sel_valid(valid_a), .slot_start(start_a), .busy(busy_a)
    );

    rr_sel_sequencer #(.SLOT_CYCLES(1), .SKIP_IDLE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .req(req_b),
        .sel(sel_b), .sel_valid(valid_b), .slot_start(start_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic push(input bit which, input logic [1:0] s, input logic v,
                        input logic st, input logic b);
        exp_t x;
        x.dut_b = which; x.sel = s; x.valid = v; x.start = st; x.busy = b;
        x.id = step_id;
        step_id++;
        sb.push_back(x);
    endtask

    task automatic step(input bit which, input logic [1:0] s, input logic v,
                        input logic st, input logic b);
        @(posedge clk);
        #1;
        push(which, s, v, st, b);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            act  = e.dut_b ? {sel_b, valid_b, start_b, busy_b}
                           : {sel_a, valid_a, start_a, busy_a};
            want = {e.sel, e.valid, e.start, e.busy};
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL step%0d dut_%s got sel=%0d valid=%0b start=%0b busy=%0b want sel=%0d valid=%0b start=%0b busy=%0b",
                         e.id, e.dut_b ? "b" : "a", act[4:3], act[2], act[1], act[0],
                         want[4:3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; req_a = 4'b0000; req_b = 4'b0000;
        #1;
        push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        push(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;

        // Two alternating requesters.
        reset = 1'b0; en_a = 1'b1; req_a = 4'b0101;
        for (int k = 0; k < 12; k++)
            step(1'b0, ((k / 4) % 2 == 1) ? 2'd2 : 2'd0, 1'b1, (k % 4) == 0, 1'b1);

        // Single requester re-wins every slot.
        req_a = 4'b1000;
        for (int k = 0; k < 12; k++)
            step(1'b0, 2'd3, 1'b1, (k % 4) == 0, 1'b1);

        // Park pointer on ch0, then all request -> ch1, then drop requests mid-slot.
        req_a = 4'b0001;
        step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        req_a = 4'b1111;
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
        req_a = 4'b0000;
        for (int k = 0; k < 3; k++) step(1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

        // en dropped mid-slot: slot completes, then IDLE; re-enable continues round robin.
        req_a = 4'b0011;
        step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        en_a = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        en_a = 1'b1;
        step(1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges while holding a slot.
        @(posedge clk); #2;
        reset = 1'b1;
        push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0; req_a = 4'b0110; en_a = 1'b1;
        step(1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd2, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd2, 1'b1, 1'b0, 1'b1);
        en_a = 1'b0;

        // One-cycle slots visiting every channel with no requests.
        en_b = 1'b1;
        for (int k = 0; k < 6; k++)
            step(1'b1, 2'(k % 4), 1'b1, 1'b1, 1'b1);
        en_b = 1'b0;

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
